// File: rtl/kernel_conv_engine.sv
// KxK convolution engine: per-tap multiply in stage 1, reduce/shift/clamp in stage 2.
// Valid/ready on both sides; user coefficients loaded through a wrapping write pointer.

module kcv_tap #(
    parameter int ROW       = 0,
    parameter int COL       = 0,
    parameter int DATA_SIZE = 8,
    parameter int COEF_SIZE = 5,
    parameter int CW        = 5
) (
    input  logic [DATA_SIZE-1:0]        i_pix,
    input  logic [2:0]                  i_mode,
    input  logic signed [COEF_SIZE-1:0] i_coef,
    output logic signed [DATA_SIZE+CW:0] o_prod
);
    localparam int PW       = DATA_SIZE + CW + 1;
    localparam bit CTR_TAP  = (ROW == 1) && (COL == 1);
    localparam bit EDGE_TAP = (ROW == 1) != (COL == 1);
    localparam int GW       = (ROW == 1 ? 2 : 1) * (COL == 1 ? 2 : 1);
    localparam int L8W      = CTR_TAP ? 8 : -1;
    localparam int L4W      = CTR_TAP ? 4 : (EDGE_TAP ? -1 : 0);

    logic signed [CW-1:0] w;

    always_comb begin
        w = '0;
        case (i_mode)
            3'd0:    w = CW'(1);
            3'd1:    w = CW'(GW);
            3'd2:    w = CW'(L8W);
            3'd3:    w = CW'(L4W);
            3'd4:    w = CW'(i_coef);
            default: w = '0;
        endcase
    end

    assign o_prod = PW'($signed({1'b0, i_pix})) * PW'(w);
endmodule

module kernel_conv_engine #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int COEF_SIZE   = 5
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst,
    input  logic [2:0]                                          i_config_select,
    input  logic                                                i_valid,
    input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] i_data,
    output logic                                                o_ready,
    output logic                                                o_valid,
    input  logic                                                i_ready,
    output logic [DATA_SIZE-1:0]                                o_data,
    output logic                                                o_sat,
    input  logic                                                i_coef_wr,
    input  logic signed [COEF_SIZE-1:0]                         i_coef_data,
    input  logic                                                i_coef_clr,
    input  logic [3:0]                                          i_user_shift,
    output logic                                                o_coef_full
);
    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    // Fixed kernels need values up to 8, so taps are at least 5 bits signed.
    localparam int CW    = (COEF_SIZE > 5) ? COEF_SIZE : 5;
    localparam int PW    = DATA_SIZE + CW + 1;
    localparam int ACC_W = DATA_SIZE + CW + $clog2(KK) + 2;
    localparam int PTR_W = $clog2(KK);
    localparam int CTR   = KERNEL_SIZE / 2;
    localparam logic signed [ACC_W-1:0] MAX_PIX = {{(ACC_W-DATA_SIZE){1'b0}}, {DATA_SIZE{1'b1}}};

    logic                        s1_valid_q, s1_valid_d;
    logic signed [PW-1:0]        prod_q [KK];
    logic signed [PW-1:0]        prod_d [KK];
    logic signed [PW-1:0]        prod_w [KK];
    logic [3:0]                  shift_q, shift_d;
    logic                        bypass_q, bypass_d;
    logic [DATA_SIZE-1:0]        centre_q, centre_d;
    logic                        o_valid_q, o_valid_d;
    logic [DATA_SIZE-1:0]        o_data_q, o_data_d;
    logic                        o_sat_q, o_sat_d;
    logic signed [COEF_SIZE-1:0] coef_q [KK];
    logic signed [COEF_SIZE-1:0] coef_d [KK];
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic                        full_q, full_d;

    logic                        en, s1_load, accept;
    logic [2:0]                  mode_in;
    logic [3:0]                  shift_in;
    logic                        bypass_in;
    logic signed [ACC_W-1:0]     sum, shifted;
    logic [DATA_SIZE-1:0]        res_data;
    logic                        res_sat;

    assign en      = i_ready || !o_valid_q;
    assign s1_load = !s1_valid_q || en;
    assign accept  = i_valid && s1_load;
    assign o_ready = s1_load;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;
    assign o_coef_full = full_q;

    // Resolve the mode once at acceptance; the decoded mode and shift travel with the beat.
    always_comb begin
        mode_in   = i_config_select;
        shift_in  = 4'd0;
        bypass_in = 1'b0;
        if (KERNEL_SIZE != 3 && (i_config_select inside {3'd1, 3'd2, 3'd3}))
            mode_in = 3'd0;
        case (mode_in)
            3'd0:       shift_in = 4'd3;
            3'd1:       shift_in = 4'd4;
            3'd2, 3'd3: shift_in = 4'd0;
            3'd4:       shift_in = i_user_shift;
            default:    bypass_in = 1'b1;
        endcase
    end

    // Taps read coef_q, so a same-cycle coefficient write lands after this beat.
    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_col
            kcv_tap #(
                .ROW(r), .COL(c), .DATA_SIZE(DATA_SIZE), .COEF_SIZE(COEF_SIZE), .CW(CW)
            ) u_tap (
                .i_pix (i_data[r][c]),
                .i_mode(mode_in),
                .i_coef(coef_q[r*KERNEL_SIZE+c]),
                .o_prod(prod_w[r*KERNEL_SIZE+c])
            );
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < KK; i++)
            sum = sum + ACC_W'(prod_q[i]);
        shifted  = sum >>> shift_q;
        res_data = shifted[DATA_SIZE-1:0];
        res_sat  = 1'b0;
        if (bypass_q) begin
            res_data = centre_q;
        end else if (shifted[ACC_W-1]) begin
            res_data = '0;
            res_sat  = 1'b1;
        end else if (shifted > MAX_PIX) begin
            res_data = '1;
            res_sat  = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_load ? accept : s1_valid_q;
        shift_d    = accept ? shift_in : shift_q;
        bypass_d   = accept ? bypass_in : bypass_q;
        centre_d   = accept ? i_data[CTR][CTR] : centre_q;
        for (int i = 0; i < KK; i++)
            prod_d[i] = accept ? prod_w[i] : prod_q[i];
        o_valid_d = en ? s1_valid_q : o_valid_q;
        o_data_d  = (en && s1_valid_q) ? res_data : o_data_q;
        o_sat_d   = (en && s1_valid_q) ? res_sat : o_sat_q;
    end

    always_comb begin
        coef_d = coef_q;
        ptr_d  = ptr_q;
        full_d = full_q;
        if (i_coef_clr) begin
            ptr_d  = '0;
            full_d = 1'b0;
        end else if (i_coef_wr) begin
            coef_d[ptr_q] = i_coef_data;
            ptr_d = (ptr_q == PTR_W'(KK-1)) ? '0 : ptr_q + 1'b1;
            if (ptr_q == PTR_W'(KK-1))
                full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= 1'b0;
            ptr_q      <= '0;
            full_q     <= 1'b0;
            for (int i = 0; i < KK; i++)
                coef_q[i] <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_sat_q    <= o_sat_d;
            ptr_q      <= ptr_d;
            full_q     <= full_d;
            coef_q     <= coef_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q and needs no reset.
    always_ff @(posedge i_clk) begin
        prod_q   <= prod_d;
        shift_q  <= shift_d;
        bypass_q <= bypass_d;
        centre_q <= centre_d;
    end
endmodule

// File: tb/tb_kernel_conv_engine.sv
// Randomized scoreboard bench for kernel_conv_engine against an arithmetic reference model.

module tb_kernel_conv_engine;
    localparam int K = 3;
    localparam int D = 8;
    localparam int C = 5;

    logic                         i_clk = 1'b0;
    logic                         i_rst;
    logic [2:0]                   i_config_select;
    logic                         i_valid;
    logic [K-1:0][K-1:0][D-1:0]   i_data;
    logic                         o_ready;
    logic                         o_valid;
    logic                         i_ready;
    logic [D-1:0]                 o_data;
    logic                         o_sat;
    logic                         i_coef_wr;
    logic signed [C-1:0]          i_coef_data;
    logic                         i_coef_clr;
    logic [3:0]                   i_user_shift;
    logic                         o_coef_full;

    kernel_conv_engine #(.KERNEL_SIZE(K), .DATA_SIZE(D), .COEF_SIZE(C)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_config_select(i_config_select),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat), .i_coef_wr(i_coef_wr),
        .i_coef_data(i_coef_data), .i_coef_clr(i_coef_clr),
        .i_user_shift(i_user_shift), .o_coef_full(o_coef_full)
    );

    always #5 i_clk = ~i_clk;

    int         checks = 0;
    int         failures = 0;
    logic [D:0] exp_q [$];
    int         win [3][3];
    int         cf_m [9];
    int         ptr_m = 0;
    bit         full_m = 1'b0;
    bit         rdy_rand = 1'b0;
    bit         rdy_force = 1'b1;
    bit         hold_pending = 1'b0;
    logic [D:0] hold_v;
    logic [D:0] mon_e;
    int         gk [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    function automatic logic [D:0] model(input int mode, input int ush);
        int w, sh, sum;
        if (mode >= 5) return {1'b0, 8'(win[1][1])};
        sum = 0;
        for (int i = 0; i < 9; i++) begin
            case (mode)
                0: w = 1;
                1: w = gk[i];
                2: w = (i == 4) ? 8 : -1;
                3: w = (i == 4) ? 4 : ((i % 2 == 1) ? -1 : 0);
                default: w = cf_m[i];
            endcase
            sum += w * win[i/3][i%3];
        end
        sh = (mode == 0) ? 3 : (mode == 1) ? 4 : (mode == 4) ? ush : 0;
        sum = sum >>> sh;
        if (sum < 0) return {1'b1, 8'd0};
        if (sum > 255) return {1'b1, 8'hff};
        return {1'b0, 8'(sum)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_coef(input bit wr, input bit clr, input int v);
        if (clr) begin
            ptr_m = 0;
            full_m = 1'b0;
        end else if (wr) begin
            cf_m[ptr_m] = v;
            if (ptr_m == 8) full_m = 1'b1;
            ptr_m = (ptr_m + 1) % 9;
        end
    endtask

    task automatic set_win(input int v, input int centre);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win[r][c] = v;
        win[1][1] = centre;
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic coef_op(input bit wr, input bit clr, input int v);
        i_coef_wr = wr;
        i_coef_clr = clr;
        i_coef_data = C'(v);
        @(posedge i_clk);
        model_coef(wr, clr, v);
        #1;
        i_coef_wr = 1'b0;
        i_coef_clr = 1'b0;
    endtask

    task automatic send_beat(input int mode, input int ush, input bit wr, input int wv);
        int n = 0;
        bit done = 1'b0;
        i_valid = 1'b1;
        i_config_select = 3'(mode);
        i_user_shift = 4'(ush);
        i_coef_wr = wr;
        i_coef_data = C'(wv);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                i_data[r][c] = 8'(win[r][c]);
        while (!done) begin
            @(negedge i_clk);
            if (o_ready) begin
                exp_q.push_back(model(mode, ush));
                done = 1'b1;
            end
            model_coef(i_coef_wr, 1'b0, wv);
            @(posedge i_clk);
            #1;
            i_coef_wr = 1'b0;
            n++;
            if (!done && n > 50) begin
                chk("accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_coef_wr = 1'b0;
        i_coef_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        for (int i = 0; i < 9; i++) cf_m[i] = 0;
        ptr_m = 0;
        full_m = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: pops on each transfer and checks hold-stability across stalls.
    initial forever begin
        @(negedge i_clk);
        if (!i_rst) begin
            if (hold_pending) begin
                checks++;
                if (!o_valid || {o_sat, o_data} !== hold_v) begin
                    failures++;
                    $display("FAIL stall_hold actual=v%0d/%0h required=v1/%0h",
                             o_valid, {o_sat, o_data}, hold_v);
                end
            end
            hold_pending = 1'b0;
            if (o_valid) begin
                if (i_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_out actual=%0h required=none", {o_sat, o_data});
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({o_sat, o_data} !== mon_e) begin
                            failures++;
                            $display("FAIL out_beat actual=sat%0d/%0d required=sat%0d/%0d",
                                     o_sat, o_data, mon_e[D], mon_e[D-1:0]);
                        end
                    end
                end else begin
                    hold_pending = 1'b1;
                    hold_v = {o_sat, o_data};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_config_select = '0; i_data = '0;
        i_coef_wr = 1'b0; i_coef_data = '0; i_coef_clr = 1'b0; i_user_shift = '0;
        @(posedge i_clk);
        #1;
        do_reset();
        @(negedge i_clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_sat", o_sat, 0);
        chk("rst_coef_full", o_coef_full, 0);
        chk("rst_o_ready", o_ready, 1);
        @(posedge i_clk);
        #1;

        // Latency with no backpressure
        set_win(16, 16);
        send_beat(1, 0, 1'b0, 0);
        @(negedge i_clk);
        chk("lat_early", o_valid, 0);
        @(negedge i_clk);
        chk("lat_two", o_valid, 1);
        chk("gauss16", o_data, 16);
        @(posedge i_clk);
        #1;

        set_win(0, 10);   send_beat(2, 0, 1'b0, 0);
        set_win(10, 0);   send_beat(3, 0, 1'b0, 0);
        set_win(255, 255); send_beat(0, 0, 1'b0, 0);
        set_win(9, 9);    send_beat(4, 0, 1'b0, 0);
        wait_drain();

        // Coefficient load, wrap, clear priority, same-cycle write
        repeat (9) coef_op(1'b1, 1'b0, 2);
        chk("coef_full_set", o_coef_full, int'(full_m));
        set_win(5, 5);  send_beat(4, 1, 1'b0, 0);
        coef_op(1'b1, 1'b0, 3);
        set_win(1, 1);  send_beat(4, 0, 1'b0, 0);
        coef_op(1'b1, 1'b1, 7);
        chk("coef_full_clr", o_coef_full, 0);
        coef_op(1'b1, 1'b0, -1);
        send_beat(4, 0, 1'b1, 9);
        send_beat(4, 0, 1'b0, 0);
        wait_drain();

        // Back-to-back stream with a three-cycle downstream stall
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    set_win(0, k);
                    send_beat(5 + (k % 3), 0, 1'b0, 0);
                end
            end
            begin
                repeat (4) @(posedge i_clk);
                rdy_force = 1'b0;
                repeat (3) @(negedge i_clk);
                chk("stall_o_ready", o_ready, 0);
                chk("stall_o_valid", o_valid, 1);
                @(posedge i_clk);
                rdy_force = 1'b1;
            end
        join
        wait_drain();

        // Randomized traffic with random backpressure and coefficient activity
        rdy_rand = 1'b1;
        for (int b = 0; b < 300; b++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] = int'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) coef_op(1'b0, 1'b1, 0);
            send_beat(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) == 0), int'($urandom_range(0, 31)) - 16);
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        wait_drain();
        chk("rand_coef_full", o_coef_full, int'(full_m));

        // Reset with two beats in flight
        repeat (9) coef_op(1'b1, 1'b0, 1);
        chk("pre_rst_full", o_coef_full, 1);
        rdy_force = 1'b0;
        @(posedge i_clk);
        #1;
        set_win(7, 7);
        send_beat(0, 0, 1'b0, 0);
        send_beat(1, 0, 1'b0, 0);
        do_reset();
        @(negedge i_clk);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_full", o_coef_full, 0);
        chk("mid_rst_o_ready", o_ready, 1);
        @(posedge i_clk);
        #1;
        rdy_force = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;
        set_win(9, 9);
        send_beat(4, 0, 1'b0, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
